// File: rtl/pal_reg.sv
// pal_reg: serially configured PAL with shadow/active configuration and optional registered macrocells
module pal_reg #(
    parameter int N = 4,
    parameter int M = 3,
    parameter int P = 3
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CFG_EN,
    input  logic         CFG,
    input  logic         CFG_COMMIT,
    input  logic [N-1:0] INPUT_VARS,
    output logic [M-1:0] OUTPUT_VALS,
    output logic         CFG_DONE,
    output logic         CFG_ERR
);
    localparam int L  = 2*N*P + M*P + 2*M;
    localparam int CW = $clog2(L + 1);
    localparam int AB = 2*M + M*P;

    typedef enum logic [1:0] {IDLE, SHIFT, READY} state_t;

    state_t        state_q, state_d;
    logic [L-1:0]  shadow_q, shadow_d, active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  mc_q, f;
    logic [P-1:0]  term;
    logic          done_q, err_q, commit_ok, shift;

    // next-state for the configuration path; a rejected commit also blocks shifting
    always_comb begin
        commit_ok = CFG_COMMIT && !CFG_EN && state_q == READY;
        shift     = CFG_EN && !CFG_COMMIT;
        shadow_d  = shift ? {shadow_q[L-2:0], CFG} : shadow_q;
        active_d  = commit_ok ? shadow_q : active_q;
        cnt_d     = commit_ok ? '0 : (shift && cnt_q != CW'(L)) ? cnt_q + CW'(1) : cnt_q;
        state_d   = cnt_d == '0 ? IDLE : cnt_d == CW'(L) ? READY : SHIFT;
    end

    for (genvar p = 0; p < P; p++) begin : g_term
        logic [2*N-1:0] lit;
        logic [N-1:0]   ok;
        assign lit = active_q[AB + p*2*N +: 2*N];
        for (genvar i = 0; i < N; i++) begin : g_lit
            assign ok[i] = (!lit[2*i] || INPUT_VARS[i]) && (!lit[2*i+1] || !INPUT_VARS[i]);
        end
        assign term[p] = (|lit) && (&ok);
    end

    for (genvar m = 0; m < M; m++) begin : g_mc
        assign f[m]           = (|(term & active_q[2*M + m*P +: P])) ^ active_q[m];
        assign OUTPUT_VALS[m] = active_q[M + m] ? mc_q[m] : f[m];
    end

    assign CFG_DONE = done_q;
    assign CFG_ERR  = err_q;

    // configuration FSM, error pulse and macrocell flops
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            mc_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mc_q     <= f;
            done_q   <= state_d == READY;
            err_q    <= CFG_COMMIT && !commit_ok;
        end
    end
endmodule

// File: doc/pal_reg.md
PAL_REG -- requirements
Module: pal_reg

Interface
REQ-001 SHALL have parameter N, default 4, number of input variables (>=1).
REQ-002 SHALL have parameter M, default 3, number of outputs/macrocells (>=1).
REQ-003 SHALL have parameter P, default 3, number of product terms (>=1).
REQ-004 SHALL define local L = 2*N*P + M*P + 2*M, the configuration bitstream length (39 at defaults).
REQ-005 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port CFG_EN  input  1  shift-enable for configuration bitstream.
REQ-008 SHALL have port CFG  input  1  serial configuration data bit.
REQ-009 SHALL have port CFG_COMMIT  input  1  request to copy shadow config to active config.
REQ-010 SHALL have port INPUT_VARS  input  N  logic inputs.
REQ-011 SHALL have port OUTPUT_VALS  output  M  macrocell outputs.
REQ-012 SHALL have port CFG_DONE  output  1  high while exactly L bits are held in shadow.
REQ-013 SHALL have port CFG_ERR  output  1  one-cycle pulse on a rejected commit.

Function
REQ-014 SHALL keep an L-bit shadow register, an L-bit active register and a bit counter 0..L.
REQ-015 SHALL shift on each edge with CFG_EN=1: shadow <= {shadow[L-2:0], CFG}; first bit shifted ends at index L-1.
REQ-016 SHALL saturate the counter at L; further shifting still moves shadow and CFG_DONE stays 1.
REQ-017 SHALL map active bits as: POL[m]=bit m; REG[m]=bit M+m; OR[m][p]=bit 2M+m*P+p; AND true literal of input i in term p = bit 2M+MP+p*2N+2i, complement literal = that index +1.
REQ-018 SHALL evaluate term p as AND of all selected literals; a term with no literal selected SHALL evaluate 0.
REQ-019 SHALL form sum[m] = OR of terms with OR[m][p]=1, then f[m] = sum[m] XOR POL[m].
REQ-020 SHALL drive OUTPUT_VALS[m] = f[m] combinationally when REG[m]=0.
REQ-021 SHALL drive OUTPUT_VALS[m] from a flop loaded with f[m] every edge when REG[m]=1 (one-cycle latency).
REQ-022 SHALL implement states IDLE (count=0), SHIFT (0<count<L), READY (count=L).
REQ-023 SHALL accept a commit at an edge with CFG_COMMIT=1, CFG_EN=0, state READY: active <= shadow, counter <= 0, state -> IDLE.
REQ-024 SHALL reject a commit in IDLE or SHIFT, or with CFG_EN=1 in the same cycle: active unchanged, no shift in that cycle, CFG_ERR=1 for exactly the next cycle, counter preserved.
REQ-025 SHALL apply a new configuration atomically: combinational outputs change right after the commit edge; registered outputs reflect it at the following edge.
REQ-026 SHALL keep active configuration and outputs unaffected by any shifting until commit.
REQ-027 SHALL leave the shadow contents intact after commit (counter only cleared).

Reset
REQ-028 SHALL on RST_N=0 immediately clear shadow, active, counter, macrocell flops, CFG_DONE and CFG_ERR to 0, state IDLE.
REQ-029 SHALL therefore force OUTPUT_VALS to 0 during and after reset until a commit; reset mid-shift discards partial bitstream.
REQ-030 SHALL ignore CFG_EN and CFG_COMMIT while RST_N=0 and resume on the first edge after deassertion.

Verification
REQ-031 SHALL verify: N=4,M=3,P=3, shift 39 bits programming term0=IN0&IN1, OR[0][0]=1, REG=0, POL=0, commit; INPUT_VARS=0011 -> OUTPUT_VALS[0]=1; 0001 -> 0.
REQ-032 SHALL verify: same image with REG[0]=1 -> OUTPUT_VALS[0] follows inputs one cycle late; with POL[0]=1 -> inverted value (0011 -> 0).
REQ-033 SHALL verify: commit after 20 bits -> CFG_ERR pulses 1 cycle, CFG_DONE=0, outputs unchanged; shift 19 more bits -> CFG_DONE=1, commit succeeds.
REQ-034 SHALL verify: CFG_EN=1 and CFG_COMMIT=1 same cycle in READY -> CFG_ERR pulse, no shift, active unchanged.
REQ-035 SHALL verify: RST_N low mid-shift and with a committed config -> OUTPUT_VALS=0, CFG_DONE=0 immediately, re-program required.
REQ-036 SHALL verify: reprogram while live -> outputs hold old function through 39 shift cycles and switch only at the commit edge.
